wb_epb_master: RTL and testbench
================================

# wb_epb_master

Wishbone classic slave that turns 8-bit register accesses into EPB bus cycles. It issues chip-select, output-enable and write-enable strobes and waits for the peripheral's ready. This is the initiator end of the EPB interface, normally served by the CPLD's EPB-to-wishbone bridge. It is used as the bus master in gateware-level benches and in FPGA-side logic that drives the CPLD register space (system block, MMC controller) over EPB.

## Interface
Parameters:
- SETUP_CYCLES, 1, cycles epb_cs_n is low with address valid before the strobe asserts (≥1)
- HOLD_CYCLES, 1, cycles epb_cs_n, address and write data are held after the strobe deasserts (≥1)
- TIMEOUT, 64, maximum cycles spent waiting for epb_rdy_i before the access is aborted (≥1)

Ports:
- wb_clk_i  in  1  single clock; all logic is on its rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wb_cyc_i  in  1  wishbone cycle
- wb_stb_i  in  1  wishbone strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  6  register address
- wb_dat_i  in  8  write data
- wb_dat_o  out  8  read data; valid while wb_ack_o or wb_err_o is high
- wb_ack_o  out  1  one-cycle completion pulse
- wb_err_o  out  1  one-cycle timeout pulse
- epb_cs_n  out  1  chip select, active-low
- epb_oe_n  out  1  read strobe, active-low
- epb_we_n  out  1  write strobe, active-low
- epb_addr  out  6  address, maps to epb_paddr[26:31]
- epb_data_o  out  8  write data
- epb_data_oe  out  1  write-data drive enable for the top-level tri-state
- epb_data_i  in  8  read data from the bus
- epb_rdy_i  in  1  peripheral ready, active-high, synchronous to wb_clk_i
- busy_o  out  1  high in every state except IDLE

## Operation
- State machine: IDLE → SETUP → STROBE → HOLD → DONE → IDLE.
- **IDLE**
  - Accepts a request on wb_cyc_i & wb_stb_i.
  - Latches adr, we and dat_i into registers.
  - Moves to SETUP.
- **SETUP**
  - epb_cs_n=0 and epb_addr driven.
  - For writes, epb_data_oe=1 and epb_data_o driven.
  - Lasts SETUP_CYCLES cycles (down-counter), then moves to STROBE.
- **STROBE**
  - For a read, epb_oe_n=0; for a write, epb_we_n=0.
  - The wait counter starts at 0 on entry and increments each cycle.
  - If epb_rdy_i is sampled high: for a read, capture epb_data_i into the read-data register, then go to HOLD with the timeout flag cleared.
  - If the counter reaches TIMEOUT-1 with epb_rdy_i low: read data becomes 8'hFF, the timeout flag is set, and the state moves to HOLD.
- **HOLD**
  - Strobes return high; epb_cs_n stays 0.
  - Address and write data are unchanged.
  - Lasts HOLD_CYCLES cycles.
- **DONE**
  - epb_cs_n=1 and epb_data_oe=0.
  - If wb_cyc_i is high: pulse wb_ack_o (no timeout) or wb_err_o (timeout) for one cycle, with wb_dat_o showing the read-data register.
  - If wb_cyc_i is low, the response is dropped because the master abandoned the cycle.
  - Always returns to IDLE.
- epb_oe_n and epb_we_n are never low together. No strobe is low outside STROBE.
- Wishbone inputs are ignored outside IDLE. A request still asserted in the cycle after DONE counts as a new request.
- Counter widths are $clog2 of the parameter +1 and must not wrap within one phase.

## Timing
- Reset values, applied on the first edge with wb_rst_i=1:
  - epb_cs_n=1, epb_oe_n=1, epb_we_n=1
  - epb_addr=0, epb_data_o=0, epb_data_oe=0
  - wb_dat_o=0, wb_ack_o=0, wb_err_o=0, busy_o=0
  - state=IDLE
- Reset in the middle of an access abandons it immediately. The outputs above take their reset values on that edge and no ack or err is issued.
- All outputs are registered, with no combinational path from input to output.
- Latency, where the request is sampled at edge n and W is the number of cycles in STROBE before ready (W≥1):
  - SETUP is active from n+1.
  - STROBE is active from n+1+SETUP_CYCLES.
  - The ack/err pulse occurs at n+1+SETUP_CYCLES+W+HOLD_CYCLES.
  - With defaults and ready on the first STROBE cycle, ack arrives at n+4.
- A timeout gives W=TIMEOUT.
- epb_rdy_i is only sampled in STROBE; a ready held high from an earlier access has no effect until then.
- Back-to-back accesses have a minimum of one IDLE cycle between DONE and the next SETUP, during which epb_cs_n=1.

## Test plan
- **Single write:** write adr 6'h12, data 8'hA5, responder gives ready on the first STROBE cycle.
  - epb_we_n low for exactly 1 cycle, epb_addr=6'h12, epb_data_o=8'hA5 with epb_data_oe high from SETUP through HOLD.
  - wb_ack_o at n+4; epb_oe_n stays 1 throughout.
- **Read with wait states:** read adr 6'h10, ready given after 5 STROBE cycles with data 8'h3C.
  - epb_oe_n low for 5 cycles.
  - wb_dat_o=8'h3C with wb_ack_o at n+8.
- **Timeout:** TIMEOUT=8 and ready never asserted.
  - Strobe low for 8 cycles.
  - wb_err_o pulses for one cycle, wb_ack_o stays 0, wb_dat_o=8'hFF.
  - busy_o returns to 0 afterwards.
- **Back-to-back:** stb held high across write then read.
  - epb_cs_n high for at least 1 cycle between the two accesses.
  - Second access uses the new address and direction.
- **Reset mid-STROBE:** assert wb_rst_i for 1 cycle during a read.
  - All EPB outputs idle on the next edge.
  - No ack or err; the next request completes normally.
- **Abandoned cycle:** drop wb_cyc_i during HOLD.
  - EPB access completes.
  - No ack or err is issued.

Source files
------------

// File: rtl/wb_epb_master.sv
// Wishbone classic slave that runs each 8-bit register access as one EPB chip-select/strobe cycle.
// Latency: ack/err is visible SETUP_CYCLES+W+HOLD_CYCLES cycles after the request edge (W = strobe cycles until ready).
// Backpressure: the wishbone side stalls until ack/err; epb_rdy_i stretches STROBE up to TIMEOUT cycles.
module wb_epb_master #(
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1,
    parameter int TIMEOUT      = 64
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [5:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic       wb_err_o,
    output logic       epb_cs_n,
    output logic       epb_oe_n,
    output logic       epb_we_n,
    output logic [5:0] epb_addr,
    output logic [7:0] epb_data_o,
    output logic       epb_data_oe,
    input  logic [7:0] epb_data_i,
    input  logic       epb_rdy_i,
    output logic       busy_o
);
    localparam int PW = $clog2(SETUP_CYCLES > HOLD_CYCLES ? SETUP_CYCLES : HOLD_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [PW-1:0] SETUP_LOAD = PW'(SETUP_CYCLES - 1);
    localparam logic [PW-1:0] HOLD_LOAD  = PW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] phase_cnt, phase_cnt_nxt;
    logic [TW-1:0] wait_cnt, wait_cnt_nxt;
    logic          we_q, we_nxt;
    logic          timeout_q, timeout_nxt;
    logic [5:0]    adr_nxt;
    logic [7:0]    wr_dat_nxt;
    logic [7:0]    rd_dat_nxt;
    logic          active_nxt;
    logic          ack_nxt, err_nxt;

    // epb_addr, epb_data_o and wb_dat_o double as the latched address, write data and read-data register.
    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        wait_cnt_nxt  = wait_cnt;
        we_nxt        = we_q;
        timeout_nxt   = timeout_q;
        adr_nxt       = epb_addr;
        wr_dat_nxt    = epb_data_o;
        rd_dat_nxt    = wb_dat_o;
        case (state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    state_nxt     = SETUP;
                    phase_cnt_nxt = SETUP_LOAD;
                    we_nxt        = wb_we_i;
                    adr_nxt       = wb_adr_i;
                    wr_dat_nxt    = wb_dat_i;
                end
            end
            SETUP: begin
                if (phase_cnt == '0) begin
                    state_nxt    = STROBE;
                    wait_cnt_nxt = '0;
                end else begin
                    phase_cnt_nxt = phase_cnt - PW'(1);
                end
            end
            STROBE: begin
                if (epb_rdy_i) begin
                    state_nxt     = HOLD;
                    phase_cnt_nxt = HOLD_LOAD;
                    timeout_nxt   = 1'b0;
                    if (!we_q) begin
                        rd_dat_nxt = epb_data_i;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt     = HOLD;
                    phase_cnt_nxt = HOLD_LOAD;
                    timeout_nxt   = 1'b1;
                    rd_dat_nxt    = 8'hFF;
                end else begin
                    wait_cnt_nxt = wait_cnt + TW'(1);
                end
            end
            HOLD: begin
                if (phase_cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    phase_cnt_nxt = phase_cnt - PW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are flopped from the next state so nothing combinational reaches a pin; the
    // response decision therefore uses wb_cyc_i as sampled on the edge that enters DONE.
    always_comb begin
        active_nxt = state_nxt inside {SETUP, STROBE, HOLD};
        ack_nxt    = (state_nxt == DONE) && wb_cyc_i && !timeout_nxt;
        err_nxt    = (state_nxt == DONE) && wb_cyc_i && timeout_nxt;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            wait_cnt    <= '0;
            we_q        <= 1'b0;
            timeout_q   <= 1'b0;
            epb_cs_n    <= 1'b1;
            epb_oe_n    <= 1'b1;
            epb_we_n    <= 1'b1;
            epb_addr    <= '0;
            epb_data_o  <= '0;
            epb_data_oe <= 1'b0;
            wb_dat_o    <= '0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase_cnt   <= phase_cnt_nxt;
            wait_cnt    <= wait_cnt_nxt;
            we_q        <= we_nxt;
            timeout_q   <= timeout_nxt;
            epb_cs_n    <= !active_nxt;
            epb_oe_n    <= !((state_nxt == STROBE) && !we_nxt);
            epb_we_n    <= !((state_nxt == STROBE) && we_nxt);
            epb_addr    <= adr_nxt;
            epb_data_o  <= wr_dat_nxt;
            epb_data_oe <= active_nxt && we_nxt;
            wb_dat_o    <= rd_dat_nxt;
            wb_ack_o    <= ack_nxt;
            wb_err_o    <= err_nxt;
            busy_o      <= (state_nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_wb_epb_master.sv
// Randomized scoreboard bench for wb_epb_master with a responding EPB peripheral model.
module tb_wb_epb_master;
    localparam int S = 1;
    localparam int H = 1;
    localparam int T = 8;

    typedef struct {
        int         cs_len;
        int         strb_len;
        bit         we;
        logic [5:0] adr;
        logic [7:0] dat;
    } epb_exp_t;

    typedef struct {
        bit         err;
        logic [7:0] dat;
        int         cyc;
    } rsp_exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cyc = 1'b0;
    logic       stb = 1'b0;
    logic       we  = 1'b0;
    logic [5:0] adr = '0;
    logic [7:0] dat = '0;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o, wb_err_o;
    logic       epb_cs_n, epb_oe_n, epb_we_n, epb_data_oe, busy_o;
    logic [5:0] epb_addr;
    logic [7:0] epb_data_o;
    logic [7:0] epb_data_i = '0;
    logic       epb_rdy_i  = 1'b0;

    wb_epb_master #(.SETUP_CYCLES(S), .HOLD_CYCLES(H), .TIMEOUT(T)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .epb_cs_n(epb_cs_n), .epb_oe_n(epb_oe_n), .epb_we_n(epb_we_n),
        .epb_addr(epb_addr), .epb_data_o(epb_data_o), .epb_data_oe(epb_data_oe),
        .epb_data_i(epb_data_i), .epb_rdy_i(epb_rdy_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc_cnt = 0;
    rsp_exp_t   rsp_q[$];
    epb_exp_t   epb_q[$];
    logic [7:0] last_rd = '0;
    int         resp_wait = 1;
    logic [7:0] resp_dat = '0;
    bit         rdy_pre = 1'b0;
    bit         abort_flag = 1'b0;
    bit         stray = 1'b0;

    localparam logic [28:0] IDLE_OUTS = {3'b111, 6'h00, 8'h00, 1'b0, 8'h00, 3'b000};

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic bound_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc_cnt);
    endtask

    // Peripheral: ready in the resp_wait-th strobe cycle (0 = never); ready outside the
    // strobe is a don't-care the master must ignore, so it is driven randomly.
    int s_cnt = 0;
    always @(negedge clk) begin
        if (!epb_oe_n || !epb_we_n) begin
            s_cnt++;
            epb_rdy_i = (resp_wait != 0) && (s_cnt == resp_wait);
        end else begin
            s_cnt = 0;
            epb_rdy_i = rdy_pre;
        end
        epb_data_i = epb_rdy_i ? resp_dat : 8'($urandom);
    end

    // Wishbone response monitor.
    rsp_exp_t mon_r;
    always @(negedge clk) begin
        if (wb_ack_o || wb_err_o) begin
            if (rsp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: ack=%0b err=%0b at cycle %0d, expected none",
                         wb_ack_o, wb_err_o, cyc_cnt);
            end else begin
                mon_r = rsp_q.pop_front();
                check("rsp_kind", {wb_ack_o, wb_err_o}, mon_r.err ? 2'b01 : 2'b10);
                check("rsp_dat", wb_dat_o, mon_r.dat);
                check("rsp_cycle", cyc_cnt, mon_r.cyc);
            end
        end
    end

    // EPB monitor: summarises each chip-select window and compares it on the rising cs_n.
    int         cs_cnt = 0, st_cnt = 0, doe_cnt = 0;
    bit         saw_oe = 0, saw_we = 0, both = 0, chg = 0, prev_low = 0;
    logic [5:0] a0 = '0;
    logic [7:0] d0 = '0;
    epb_exp_t   mon_e;
    always @(negedge clk) begin
        if (!epb_cs_n) begin
            if (!prev_low) begin
                a0 = epb_addr;
                d0 = epb_data_o;
            end else if (epb_addr !== a0 || epb_data_o !== d0) begin
                chg = 1;
            end
            cs_cnt++;
            if (!epb_oe_n) saw_oe = 1;
            if (!epb_we_n) saw_we = 1;
            if (!epb_oe_n || !epb_we_n) st_cnt++;
            if (!epb_oe_n && !epb_we_n) both = 1;
            if (epb_data_oe) doe_cnt++;
            prev_low = 1;
        end else begin
            if (!epb_oe_n || !epb_we_n || epb_data_oe) stray = 1;
            if (prev_low && !abort_flag) begin
                if (epb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_epb: cs window of %0d cycles at cycle %0d, expected none",
                             cs_cnt, cyc_cnt);
                end else begin
                    mon_e = epb_q.pop_front();
                    check("cs_len", cs_cnt, mon_e.cs_len);
                    check("strobe_len", st_cnt, mon_e.strb_len);
                    check("strobe_dir", {saw_we, saw_oe}, {mon_e.we, !mon_e.we});
                    check("strobe_overlap", both, 0);
                    check("epb_addr", a0, mon_e.adr);
                    check("epb_stable", chg, 0);
                    check("data_oe_len", doe_cnt, mon_e.we ? mon_e.cs_len : 0);
                    if (mon_e.we) check("epb_data_o", d0, mon_e.dat);
                end
            end
            cs_cnt = 0; st_cnt = 0; doe_cnt = 0;
            saw_oe = 0; saw_we = 0; both = 0; chg = 0; prev_low = 0;
        end
    end

    // Reference model: an access holds cs for S+W+H cycles with the strobe low W cycles, where
    // W is the ready cycle or T on timeout. With the request sampled on edge n, the response
    // occupies cycle n+1+S+W+H, i.e. it is visible after edge n+S+W+H. lag = cycles to edge n.
    task automatic issue(input bit w, input logic [5:0] a, input logic [7:0] d, input int wt,
                         input logic [7:0] rd, input bit drop, input int lag);
        bit       to;
        int       weff;
        epb_exp_t e;
        rsp_exp_t r;
        to   = (wt == 0) || (wt > T);
        weff = to ? T : wt;
        resp_wait = wt;
        resp_dat  = rd;
        rdy_pre   = 1'($urandom);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
        e.cs_len = S + weff + H; e.strb_len = weff; e.we = w; e.adr = a; e.dat = d;
        epb_q.push_back(e);
        if (to) last_rd = 8'hFF;
        else if (!w) last_rd = rd;
        if (!drop) begin
            r.err = to; r.dat = last_rd; r.cyc = cyc_cnt + lag + S + weff + H;
            rsp_q.push_back(r);
        end
    endtask

    task automatic wait_idle();
        int k;
        cyc = 1'b0; stb = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy_o) break;
        end
        if (k == 200) bound_fail("idle_wait");
    endtask

    // Non-drop: returns on the negedge showing ack/err. Drop: releases cyc in HOLD, returns idle.
    task automatic finish_access(input bit drop);
        int k;
        bit prev_st;
        prev_st = 0;
        if (drop) begin
            for (k = 0; k < 200; k++) begin
                @(negedge clk);
                if (prev_st && epb_oe_n && epb_we_n) break;
                prev_st = !epb_oe_n || !epb_we_n;
            end
            if (k == 200) bound_fail("hold_wait");
            wait_idle();
        end else begin
            for (k = 0; k < 200; k++) begin
                @(negedge clk);
                if (wb_ack_o || wb_err_o) break;
            end
            if (k == 200) bound_fail("rsp_wait");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  lag;
        bit  w, drop;
        int  wt;
        @(negedge clk);
        check("reset_outputs", {epb_cs_n, epb_oe_n, epb_we_n, epb_addr, epb_data_o, epb_data_oe,
                                wb_dat_o, wb_ack_o, wb_err_o, busy_o}, IDLE_OUTS);
        @(negedge clk);
        rst = 1'b0;

        issue(1'b1, 6'h12, 8'hA5, 1, 8'h00, 1'b0, 1); finish_access(1'b0); wait_idle();
        issue(1'b0, 6'h10, 8'h00, 5, 8'h3C, 1'b0, 1); finish_access(1'b0); wait_idle();
        issue(1'b0, 6'h2A, 8'h00, 0, 8'h55, 1'b0, 1); finish_access(1'b0); wait_idle();
        check("busy_after_timeout", busy_o, 0);

        // Back-to-back: the read is presented in the DONE cycle of the write.
        issue(1'b1, 6'h05, 8'h77, 2, 8'h00, 1'b0, 1); finish_access(1'b0);
        issue(1'b0, 6'h33, 8'h00, 1, 8'hC3, 1'b0, 2); finish_access(1'b0); wait_idle();

        // Reset in the middle of a read strobe.
        resp_wait = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'h21;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!epb_oe_n) break;
        end
        if (k == 50) bound_fail("abort_strobe_wait");
        @(negedge clk);
        abort_flag = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_abort_outputs", {epb_cs_n, epb_oe_n, epb_we_n, epb_addr, epb_data_o, epb_data_oe,
                                      wb_dat_o, wb_ack_o, wb_err_o, busy_o}, IDLE_OUTS);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        last_rd = 8'h00;
        @(negedge clk);
        @(negedge clk);
        abort_flag = 1'b0;
        issue(1'b0, 6'h21, 8'h00, 3, 8'h9E, 1'b0, 1); finish_access(1'b0); wait_idle();

        // Master abandons the cycle during HOLD; the read data is still captured.
        issue(1'b0, 6'h3F, 8'h00, 2, 8'h18, 1'b1, 1); finish_access(1'b1);
        issue(1'b1, 6'h01, 8'h42, 1, 8'h00, 1'b0, 1); finish_access(1'b0); wait_idle();

        lag = 1;
        for (int i = 0; i < 60; i++) begin
            w    = 1'($urandom);
            wt   = $urandom_range(0, T + 2);
            drop = ($urandom_range(0, 7) == 0);
            issue(w, 6'($urandom), 8'($urandom), wt, 8'($urandom), drop, lag);
            finish_access(drop);
            if (!drop && $urandom_range(0, 2) == 0) begin
                lag = 2;
            end else begin
                if (!drop) wait_idle();
                lag = 1;
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);

        check("rsp_queue_drained", rsp_q.size(), 0);
        check("epb_queue_drained", epb_q.size(), 0);
        check("stray_strobe", stray, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
